// File: rtl/mux2_1_arb.sv
// Round-robin arbiter for the shared mux2_1 channel: registered grant FSM with
// a bounded burst length, mux select generation and a registered output word.
module mux2_1_arb #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req1,
    input  logic              req2,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic              grant1,
    output logic              grant2,
    output logic              sel,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic [CW-1:0]     hold_q, hold_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              vld_q, vld_d;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            hold_q  <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        hold_d  = hold_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req1 && (!req2 || !prio_q)) begin
                    state_d = GNT1;
                end else if (req2) begin
                    state_d = GNT2;
                end
            end
            GNT1: begin
                if (req1) begin
                    out_d = in1;
                    vld_d = 1'b1;
                    if (hold_q == LAST) begin
                        if (req2) state_d = GNT2;
                        else      hold_d  = '0;
                    end else begin
                        hold_d = hold_q + CW'(1);
                    end
                end else begin
                    state_d = req2 ? GNT2 : IDLE;
                end
            end
            GNT2: begin
                if (req2) begin
                    out_d = in2;
                    vld_d = 1'b1;
                    if (hold_q == LAST) begin
                        if (req1) state_d = GNT1;
                        else      hold_d  = '0;
                    end else begin
                        hold_d = hold_q + CW'(1);
                    end
                end else begin
                    state_d = req1 ? GNT1 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any state change restarts the burst; entering a grant hands the tie to the other side.
        if (state_d != state_q) begin
            hold_d = '0;
            if (state_d == GNT1)      prio_d = 1'b1;
            else if (state_d == GNT2) prio_d = 1'b0;
        end
    end

    assign grant1    = (state_q == GNT1);
    assign grant2    = (state_q == GNT2);
    assign sel       = (state_q == GNT1);
    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_mux2_1_arb.sv
// Self-checking bench for mux2_1_arb: directed scenarios followed by random
// traffic, all compared against a transaction-level arbitration model.
module tb_mux2_1_arb;

    localparam int DW = 8;
    localparam int MH = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          req1 = 1'b0, req2 = 1'b0;
    logic [DW-1:0] in1 = '0, in2 = '0;
    logic          grant1, grant2, sel, out_valid;
    logic [DW-1:0] out;

    mux2_1_arb #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req1(req1), .req2(req2), .in1(in1), .in2(in2),
        .grant1(grant1), .grant2(grant2), .sel(sel),
        .out(out), .out_valid(out_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: current owner (0 none, 1, 2), tie preference,
    // transfers made in the current grant, and the output word.
    int            m_own = 0;
    bit            m_prio = 1'b0;
    int            m_n = 0;
    logic [DW-1:0] m_out = '0;
    bit            m_vld = 1'b0;

    task automatic model_step(input bit rst, input bit r1, input bit r2,
                              input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        int nxt;
        bit mine, other, xfer;
        if (rst) begin
            m_own = 0; m_prio = 0; m_n = 0; m_out = '0; m_vld = 0;
            return;
        end
        nxt  = m_own;
        xfer = 0;
        if (m_own == 0) begin
            if (r1 && r2)  nxt = m_prio ? 2 : 1;
            else if (r1)   nxt = 1;
            else if (r2)   nxt = 2;
        end else begin
            mine  = (m_own == 1) ? r1 : r2;
            other = (m_own == 1) ? r2 : r1;
            if (!mine) begin
                nxt = other ? 3 - m_own : 0;
            end else begin
                xfer = 1;
                m_n++;
                if ((m_n % MH) == 0 && other) nxt = 3 - m_own;
            end
        end
        m_vld = xfer;
        if (xfer) m_out = (m_own == 1) ? d1 : d2;
        if (nxt != m_own) begin
            m_n = 0;
            if (nxt == 1) m_prio = 1;
            if (nxt == 2) m_prio = 0;
        end
        m_own = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".grant1"},    32'(grant1),    32'(m_own == 1));
        chk({tag, ".grant2"},    32'(grant2),    32'(m_own == 2));
        chk({tag, ".sel"},       32'(sel),       32'(m_own == 1));
        chk({tag, ".out"},       32'(out),       32'(m_out));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
    endtask

    // Apply inputs, advance one edge, update the model, then sample 1 ns later.
    task automatic cyc(input string tag, input bit rst, input bit r1, input bit r2,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        sys_rst = rst; req1 = r1; req2 = r2; in1 = d1; in2 = d2;
        @(posedge sys_clk);
        model_step(rst, r1, r2, d1, d2);
        #1;
        chk_model(tag);
    endtask

    initial begin
        logic [11:0] sel_pat;
        int          r;
        sel_pat = 12'b1111_0000_1111;

        // 1: reset with both requests high, then release
        cyc("rst", 1, 1, 1, 8'hAA, 8'h55);
        cyc("rst", 1, 1, 1, 8'hAA, 8'h55);
        chk("rst.out_zero", 32'(out), 32'h0);
        cyc("rst_rel", 0, 1, 1, 8'hAA, 8'h55);
        chk("rst_rel.grant1", 32'(grant1), 32'h1);

        // 2: sole requester streams without a forced switch
        cyc("single_rst", 1, 0, 0, 0, 0);
        cyc("single_req", 0, 1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc("single", 0, 1, 0, 8'(8'h10 + i), 8'hEE);
            chk("single.out", 32'(out), 32'(8'h10 + i));
            chk("single.grant1", 32'(grant1), 32'h1);
        end

        // 3: constant contention alternates every MAX_HOLD transfers
        cyc("cont_rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc("cont", 0, 1, 1, 8'(8'h20 + i), 8'(8'h40 + i));
            chk("cont.sel_pat", 32'(sel), 32'(sel_pat[11-i]));
            if (i > 0) chk("cont.valid", 32'(out_valid), 32'h1);
        end

        // 4: early release in GNT2 hands over directly to requester 1
        cyc("rel_rst", 1, 0, 0, 0, 0);
        cyc("rel_g2", 0, 0, 1, 8'h01, 8'h02);
        cyc("rel_x1", 0, 1, 1, 8'h03, 8'h04);
        cyc("rel_x2", 0, 1, 1, 8'h05, 8'h06);
        cyc("rel_drop", 0, 1, 0, 8'h07, 8'h08);
        chk("rel.grant1", 32'(grant1), 32'h1);
        chk("rel.gap", 32'(out_valid), 32'h0);
        for (int i = 0; i < 5; i++) cyc("rel_after", 0, 1, 1, 8'(8'h60 + i), 8'(8'h70 + i));

        // 5: tie after requester 1 was served goes to requester 2
        cyc("tie_rst", 1, 0, 0, 0, 0);
        cyc("tie_g1", 0, 1, 0, 8'h11, 8'h22);
        cyc("tie_x1", 0, 1, 0, 8'h12, 8'h23);
        cyc("tie_idle", 0, 0, 0, 8'h13, 8'h24);
        cyc("tie_both", 0, 1, 1, 8'h14, 8'h25);
        chk("tie.grant2", 32'(grant2), 32'h1);

        // 6: reset mid-burst in GNT2, then fresh arbitration with full budget
        cyc("mid_rst0", 1, 0, 0, 0, 0);
        cyc("mid_g2", 0, 0, 1, 8'h31, 8'h41);
        cyc("mid_x1", 0, 1, 1, 8'h32, 8'h42);
        cyc("mid_x2", 0, 1, 1, 8'h33, 8'h43);
        cyc("mid_rst", 1, 1, 1, 8'h34, 8'h44);
        chk("mid_rst.grant2", 32'(grant2), 32'h0);
        for (int i = 0; i < 10; i++) cyc("mid_after", 0, 1, 1, 8'(8'h50 + i), 8'(8'h90 + i));

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            cyc("rand", (r < 2), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux2_1_arb.md
# mux2_1_arb

Round-robin arbiter that shares the single `mux2_1` output channel between two requesters. It sequences the mux select from a registered grant state machine, limits each grant to a bounded burst, and registers the selected data with a valid flag. It sits directly in front of the `mux2_1` datapath; `sel` drives the mux, and `out`/`out_valid` feed the downstream consumer.

## Interface
- `DATA_W`, default 8: width of `in1`, `in2` and `out`.
- `MAX_HOLD`, default 4: maximum consecutive granted cycles while the other requester waits. Legal values are ≥2.
- `sys_clk` input, 1 bit: sole clock, rising edge.
- `sys_rst` input, 1 bit: synchronous, active-high reset.
- `req1` input, 1 bit: requester 1 wants the channel.
- `req2` input, 1 bit: requester 2 wants the channel.
- `in1` input, DATA_W bits: requester 1 data.
- `in2` input, DATA_W bits: requester 2 data.
- `grant1` output, 1 bit: channel owned by requester 1 (registered).
- `grant2` output, 1 bit: channel owned by requester 2 (registered).
- `sel` output, 1 bit: mux select; 1 selects `in1`, 0 selects `in2`.
- `out` output, DATA_W bits: registered selected data.
- `out_valid` output, 1 bit: `out` holds a transferred word.

## Operation
- **States:** IDLE, GNT1, GNT2, one-hot or encoded. `grant1`=(state==GNT1), `grant2`=(state==GNT2), `sel`=(state==GNT1). `grant1` and `grant2` are never high together.
- **Priority pointer `prio`:** 0 means requester 1 is preferred on a tie. It is updated on every entry into GNTx to point at the other requester.
- **Hold counter `hold_cnt`:** width clog2(MAX_HOLD). It is cleared on every state change. It increments each cycle in GNTx while `reqx`=1.
- **IDLE:**
  - Only `req1` high: go to GNT1.
  - Only `req2` high: go to GNT2.
  - Both high: go to the requester indicated by `prio`.
  - Neither high: stay in IDLE.
- **GNTx, `reqx`=0 (release):**
  - Other request high: go to the other GNT directly, with no IDLE bubble.
  - Otherwise: go to IDLE.
- **GNTx, `reqx`=1 and `hold_cnt`==MAX_HOLD-1 (burst limit):**
  - Other request high: go to the other GNT.
  - Otherwise: stay in GNTx, and `hold_cnt` wraps to 0.
- **GNTx, `reqx`=1 and `hold_cnt`<MAX_HOLD-1:** stay in GNTx.
- **Transfer:** a transfer occurs at each rising edge where `grantx`=1 and `reqx`=1.
  - At that edge, `out` captures `in1` (GNT1) or `in2` (GNT2), and `out_valid` is set to 1.
  - At all other edges, `out_valid` is cleared and `out` holds its last value.
- A requester lowering `req` while granted loses the grant at the next edge. No word is transferred in that cycle.

## Timing
- **Reset** (at an edge with `sys_rst`=1; it overrides all other logic, including mid-burst):
  - State returns to IDLE.
  - `grant1`=0, `grant2`=0, `sel`=0.
  - `out`=0, `out_valid`=0.
  - `prio`=0, `hold_cnt`=0.
- **Request-to-grant latency:** `req` sampled high at edge k gives `grant` high after edge k.
- **Data latency:** data present while `grant`&`req` at edge k appears on `out` with `out_valid`=1 after edge k. This is one cycle of latency.
- **Throughput:** a continuously requesting sole requester transfers one word per cycle indefinitely.
- **Contention:** under constant contention, ownership alternates every MAX_HOLD transfers. Switchover costs zero cycles, so there is no gap in `out_valid`.
- **Simultaneous release and other request:** a direct handover occurs. The new owner's first transfer is one edge after the handover edge.
- **Simultaneous first requests from IDLE:** resolved by `prio`.

## Test plan
1. **Reset.** Assert `sys_rst` for 2 cycles with `req1`=`req2`=1. Required: all outputs 0 during and immediately after reset. `grant1`=1 one edge after reset release (prio=0).
2. **Single requester.** `req1`=1 for 10 cycles, `in1`=8'h10..8'h19 (one value per cycle), `req2`=0. Required: `grant1` stays high for all 10 cycles, with no forced switch at MAX_HOLD. `out` shows 8'h10..8'h19 with `out_valid` continuously high, each one cycle after presentation.
3. **Contention, MAX_HOLD=4.** `req1`=`req2`=1 from IDLE. Required: GNT1 for 4 cycles, GNT2 for 4, GNT1 for 4. `sel` follows 1,1,1,1,0,0,0,0,1… and `out_valid` never drops.
4. **Early release.** In GNT2 with `req1` pending, drop `req2` after 2 transfers. Required: the next edge gives `grant1`=1, `grant2`=0, with `hold_cnt` restarted. `out_valid`=0 for exactly the one cycle following the release.
5. **Tie after release.** Sequence: requester 1 served, both requesters drop to IDLE, then both assert in the same cycle. Required: the grant goes to requester 2 (prio=1).
6. **Reset mid-burst.** Assert `sys_rst` for 1 cycle in GNT2 with `hold_cnt`=2. Required: IDLE with all outputs 0. The next grant uses prio=0 and the full MAX_HOLD budget.
